// File: rtl/ace_home_ctrl_pkg.sv
// Shared ACE home-controller definitions: FSM state encoding, CR bit positions,
// snoop opcodes and response codes used by the controller and its datapath.
package ace_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        W_DATA   = 4'd1,
        W_MEM    = 4'd2,
        B_RESP   = 4'd3,
        SNP_ADDR = 4'd4,
        SNP_RESP = 4'd5,
        SNP_DATA = 4'd6,
        R_MEM    = 4'd7,
        R_DATA   = 4'd8
    } home_state_t;

    localparam int unsigned CR_DATA_XFER_BIT = 0;
    localparam int unsigned CR_ERROR_BIT     = 1;

    localparam logic [3:0] SNP_READSHARED  = 4'b0001;
    localparam logic [3:0] SNP_MAKEINVALID = 4'b1101;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // AC snoop opcode issued for a latched AR request type
    function automatic logic [3:0] snoop_code(input logic make_unique);
        return make_unique ? SNP_MAKEINVALID : SNP_READSHARED;
    endfunction

    function automatic logic [1:0] resp_code(input logic mem_err);
        return mem_err ? RESP_SLVERR : RESP_OKAY;
    endfunction

    function automatic logic cr_data_xfer(input logic [4:0] cr_resp);
        return cr_resp[CR_DATA_XFER_BIT];
    endfunction

    function automatic logic cr_error(input logic [4:0] cr_resp);
        return cr_resp[CR_ERROR_BIT];
    endfunction

endpackage

// File: rtl/ace_home_ctrl_if.sv
// ACE link handshake signals between requester/peer caches and the home controller.
// slave = controller side, master = requester/peer side.
interface ace_home_ctrl_if;

    logic AW_VALID;
    logic AW_READY;
    logic W_VALID;
    logic W_READY;
    logic B_VALID;
    logic B_READY;
    logic AR_VALID;
    logic AR_READY;
    logic R_VALID;
    logic R_READY;
    logic AC_VALID;
    logic AC_READY;
    logic CR_VALID;
    logic CR_READY;
    logic CD_VALID;
    logic CD_READY;

    modport slave (
        input  AW_VALID, W_VALID, B_READY, AR_VALID, R_READY,
               AC_READY, CR_VALID, CD_VALID,
        output AW_READY, W_READY, B_VALID, AR_READY, R_VALID,
               AC_VALID, CR_READY, CD_READY
    );

    modport master (
        output AW_VALID, W_VALID, B_READY, AR_VALID, R_READY,
               AC_READY, CR_VALID, CD_VALID,
        input  AW_READY, W_READY, B_VALID, AR_READY, R_VALID,
               AC_VALID, CR_READY, CD_READY
    );

endinterface

// File: rtl/ace_home_ctrl.sv
// ACE home controller FSM: one outstanding WriteClean or ReadShared/MakeUnique,
// snooping the peer and falling back to memory. Optional snoop timeout: ACE_HOME_SNP_TIMEOUT_EN.
module ace_home_ctrl
    import ace_pkg::*;
#(
    parameter int unsigned SNP_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    ace_home_ctrl_if.slave   ace,
    input  logic             make_unique_i,
    input  logic             data_xfer_i,
    input  logic             mem_ack_i,
    output logic             ar_en,
    output logic             aw_en,
    output logic             w_en,
    output logic             cd_en,
    output logic             mem_req,
    output logic             mem_we,
    output logic             rdata_sel_cd
);

    home_state_t state, state_nxt;
    logic        sel_cd_q, sel_cd_nxt;
    logic        snp_expired;

    logic aw_ready, w_ready, b_valid, ar_ready, r_valid;
    logic ac_valid, cr_ready, cd_ready;
    logic ar_en_c, aw_en_c, w_en_c, cd_en_c, mem_req_c, mem_we_c;

`ifdef ACE_HOME_SNP_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(SNP_TIMEOUT + 1);
    logic [CNT_W-1:0] snp_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snp_cnt <= '0;
        end else if (state != SNP_RESP) begin
            snp_cnt <= '0;
        end else if (!ace.CR_VALID) begin
            snp_cnt <= snp_cnt + 1'b1;
        end
    end

    // Leave on the cycle whose increment brings the count to SNP_TIMEOUT.
    assign snp_expired = (state == SNP_RESP) && !ace.CR_VALID &&
                         (snp_cnt == CNT_W'(SNP_TIMEOUT - 1));
`else
    logic [31:0] unused_snp_timeout;
    assign unused_snp_timeout = SNP_TIMEOUT;
    assign snp_expired        = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sel_cd_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            sel_cd_q <= sel_cd_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        sel_cd_nxt = sel_cd_q;
        aw_ready   = 1'b0;
        w_ready    = 1'b0;
        b_valid    = 1'b0;
        ar_ready   = 1'b0;
        r_valid    = 1'b0;
        ac_valid   = 1'b0;
        cr_ready   = 1'b0;
        cd_ready   = 1'b0;
        ar_en_c    = 1'b0;
        aw_en_c    = 1'b0;
        w_en_c     = 1'b0;
        cd_en_c    = 1'b0;
        mem_req_c  = 1'b0;
        mem_we_c   = 1'b0;

        case (state)
            IDLE: begin
                aw_ready   = 1'b1;
                ar_ready   = !ace.AW_VALID;
                sel_cd_nxt = 1'b0;
                if (ace.AW_VALID) begin
                    aw_en_c   = 1'b1;
                    state_nxt = W_DATA;
                end else if (ace.AR_VALID) begin
                    ar_en_c   = 1'b1;
                    state_nxt = SNP_ADDR;
                end
            end
            W_DATA: begin
                w_ready = 1'b1;
                if (ace.W_VALID) begin
                    w_en_c    = 1'b1;
                    state_nxt = W_MEM;
                end
            end
            W_MEM: begin
                mem_req_c = 1'b1;
                mem_we_c  = 1'b1;
                if (mem_ack_i) begin
                    state_nxt = B_RESP;
                end
            end
            B_RESP: begin
                b_valid = 1'b1;
                if (ace.B_READY) begin
                    state_nxt = IDLE;
                end
            end
            SNP_ADDR: begin
                ac_valid = 1'b1;
                if (ace.AC_READY) begin
                    state_nxt = SNP_RESP;
                end
            end
            SNP_RESP: begin
                cr_ready = 1'b1;
                if (ace.CR_VALID) begin
                    if (data_xfer_i) begin
                        state_nxt = SNP_DATA;
                    end else if (make_unique_i) begin
                        state_nxt = R_DATA;
                    end else begin
                        state_nxt = R_MEM;
                    end
                end else if (snp_expired) begin
                    state_nxt = make_unique_i ? R_DATA : R_MEM;
                end
            end
            SNP_DATA: begin
                cd_ready = 1'b1;
                if (ace.CD_VALID) begin
                    cd_en_c    = 1'b1;
                    sel_cd_nxt = 1'b1;
                    state_nxt  = R_DATA;
                end
            end
            R_MEM: begin
                mem_req_c = 1'b1;
                if (mem_ack_i) begin
                    state_nxt = R_DATA;
                end
            end
            R_DATA: begin
                r_valid = 1'b1;
                if (ace.R_READY) begin
                    // Clearing on the R handshake keeps the select low for all of IDLE.
                    sel_cd_nxt = 1'b0;
                    state_nxt  = IDLE;
                end
            end
            default: begin
                state_nxt  = IDLE;
                sel_cd_nxt = 1'b0;
            end
        endcase

        // Reset forces every output low immediately, even while IDLE would drive AW_READY.
        if (rst) begin
            aw_ready  = 1'b0;
            w_ready   = 1'b0;
            b_valid   = 1'b0;
            ar_ready  = 1'b0;
            r_valid   = 1'b0;
            ac_valid  = 1'b0;
            cr_ready  = 1'b0;
            cd_ready  = 1'b0;
            ar_en_c   = 1'b0;
            aw_en_c   = 1'b0;
            w_en_c    = 1'b0;
            cd_en_c   = 1'b0;
            mem_req_c = 1'b0;
            mem_we_c  = 1'b0;
        end
    end

    assign ace.AW_READY = aw_ready;
    assign ace.W_READY  = w_ready;
    assign ace.B_VALID  = b_valid;
    assign ace.AR_READY = ar_ready;
    assign ace.R_VALID  = r_valid;
    assign ace.AC_VALID = ac_valid;
    assign ace.CR_READY = cr_ready;
    assign ace.CD_READY = cd_ready;

    assign ar_en        = ar_en_c;
    assign aw_en        = aw_en_c;
    assign w_en         = w_en_c;
    assign cd_en        = cd_en_c;
    assign mem_req      = mem_req_c;
    assign mem_we       = mem_we_c;
    assign rdata_sel_cd = sel_cd_q;

endmodule

// File: tb/tb_ace_home_ctrl.sv
// Self-checking bench for ace_home_ctrl: transaction-level model compared every
// cycle, plus directed checks on latencies, arbitration and reset.
module tb_ace_home_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic make_unique_i, data_xfer_i, mem_ack_i;
    logic ar_en, aw_en, w_en, cd_en, mem_req, mem_we, rdata_sel_cd;

    int ncmp  = 0;
    int nfail = 0;
    logic checking = 1'b0;

    ace_home_ctrl_if bus();

    ace_home_ctrl #(.SNP_TIMEOUT(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .ace           (bus.slave),
        .make_unique_i (make_unique_i),
        .data_xfer_i   (data_xfer_i),
        .mem_ack_i     (mem_ack_i),
        .ar_en         (ar_en),
        .aw_en         (aw_en),
        .w_en          (w_en),
        .cd_en         (cd_en),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .rdata_sel_cd  (rdata_sel_cd)
    );

    always #5 clk = ~clk;

    // Model: what the controller is waiting for, and which source R data comes from.
    string wait_for = "req";
    logic  m_sel    = 1'b0;
    int    m_cnt    = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_for = "req";
            m_sel    = 1'b0;
        end else begin
            case (wait_for)
                "req":  if (bus.AW_VALID) wait_for = "W";
                        else if (bus.AR_VALID) wait_for = "AC";
                "W":    if (bus.W_VALID) wait_for = "memw";
                "memw": if (mem_ack_i) wait_for = "Bacc";
                "Bacc": if (bus.B_READY) wait_for = "req";
                "AC":   if (bus.AC_READY) begin wait_for = "CR"; m_cnt = 0; end
                "CR": begin
                    if (bus.CR_VALID) begin
                        if (data_xfer_i) wait_for = "CD";
                        else if (make_unique_i) wait_for = "Racc";
                        else wait_for = "memr";
                    end else begin
                        m_cnt++;
`ifdef ACE_HOME_SNP_TIMEOUT_EN
                        if (m_cnt == 16) wait_for = make_unique_i ? "Racc" : "memr";
`endif
                    end
                end
                "CD":   if (bus.CD_VALID) begin wait_for = "Racc"; m_sel = 1'b1; end
                "memr": if (mem_ack_i) wait_for = "Racc";
                "Racc": if (bus.R_READY) begin wait_for = "req"; m_sel = 1'b0; end
                default: wait_for = "req";
            endcase
        end
    end

    function automatic logic [14:0] expected();
        logic aw_r, w_r, b_v, ar_r, r_v, ac_v, cr_r, cd_r;
        logic e_ar, e_aw, e_w, e_cd, e_req, e_we;
        {aw_r, w_r, b_v, ar_r, r_v, ac_v, cr_r, cd_r} = '0;
        {e_ar, e_aw, e_w, e_cd, e_req, e_we} = '0;
        if (!rst) begin
            case (wait_for)
                "req": begin
                    aw_r = 1'b1;
                    ar_r = !bus.AW_VALID;
                    e_aw = bus.AW_VALID;
                    e_ar = bus.AR_VALID && !bus.AW_VALID;
                end
                "W":    begin w_r = 1'b1; e_w = bus.W_VALID; end
                "memw": begin e_req = 1'b1; e_we = 1'b1; end
                "Bacc": b_v = 1'b1;
                "AC":   ac_v = 1'b1;
                "CR":   cr_r = 1'b1;
                "CD":   begin cd_r = 1'b1; e_cd = bus.CD_VALID; end
                "memr": e_req = 1'b1;
                "Racc": r_v = 1'b1;
                default: ;
            endcase
        end
        return {aw_r, w_r, b_v, ar_r, r_v, ac_v, cr_r, cd_r,
                e_ar, e_aw, e_w, e_cd, e_req, e_we, m_sel && !rst};
    endfunction

    function automatic logic [14:0] actual();
        return {bus.AW_READY, bus.W_READY, bus.B_VALID, bus.AR_READY, bus.R_VALID,
                bus.AC_VALID, bus.CR_READY, bus.CD_READY,
                ar_en, aw_en, w_en, cd_en, mem_req, mem_we, rdata_sel_cd};
    endfunction

    always @(negedge clk) begin
        if (checking) begin
            logic [14:0] a, e;
            a = actual();
            e = expected();
            ncmp++;
            if (a !== e) begin
                nfail++;
                $display("FAIL cycle_outputs @%0t (%s): got %b expected %b", $time, wait_for, a, e);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0; bus.B_READY = 1'b0;
        bus.AR_VALID = 1'b0; bus.R_READY = 1'b0; bus.AC_READY = 1'b0;
        bus.CR_VALID = 1'b0; bus.CD_VALID = 1'b0;
        make_unique_i = 1'b0; data_xfer_i = 1'b0; mem_ack_i = 1'b0;
    endtask

    // Drive a ReadShared miss up to its first R_MEM cycle.
    task automatic read_miss_to_mem();
        tick(); bus.AR_VALID = 1'b1; bus.AC_READY = 1'b1; bus.CR_VALID = 1'b1;
        data_xfer_i = 1'b0; make_unique_i = 1'b0;
        tick(); bus.AR_VALID = 1'b0;
        @(negedge clk); check("miss_ac_valid", bus.AC_VALID, 1); check("miss_snpaddr_no_mem", mem_req, 0);
        tick(); bus.AC_READY = 1'b0;
        @(negedge clk); check("miss_cr_ready", bus.CR_READY, 1); check("miss_snpresp_no_mem", mem_req, 0);
        tick(); bus.CR_VALID = 1'b0;
        @(negedge clk); check("miss_mem_req", mem_req, 1); check("miss_mem_we", mem_we, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        clr();
        @(posedge clk); #1 checking = 1'b1;
        @(negedge clk);
        check("rst_aw_ready", bus.AW_READY, 0);
        check("rst_mem_req", mem_req, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("idle_aw_ready", bus.AW_READY, 1);
        check("idle_ar_ready", bus.AR_READY, 1);

        // WriteClean with 3-cycle memory and B_READY stalled for 2 cycles
        tick(); bus.AW_VALID = 1'b1;
        @(negedge clk); check("wr_aw_en", aw_en, 1);
        tick(); bus.AW_VALID = 1'b0; bus.W_VALID = 1'b1;
        @(negedge clk); check("wr_w_en", w_en, 1);
        tick(); bus.W_VALID = 1'b0;
        @(negedge clk); check("wr_mem_req", mem_req, 1); check("wr_mem_we", mem_we, 1);
        repeat (2) tick();
        tick(); mem_ack_i = 1'b1;
        tick(); mem_ack_i = 1'b0;
        @(negedge clk); check("wr_b_valid0", bus.B_VALID, 1);
        tick();
        @(negedge clk); check("wr_b_valid1", bus.B_VALID, 1);
        tick(); bus.B_READY = 1'b1;
        tick(); bus.B_READY = 1'b0;
        @(negedge clk); check("wr_done_b_valid", bus.B_VALID, 0); check("wr_done_aw_ready", bus.AW_READY, 1);

        // ReadShared snoop hit with zero-wait peers
        tick(); bus.AR_VALID = 1'b1; bus.AC_READY = 1'b1; bus.CR_VALID = 1'b1;
        data_xfer_i = 1'b1; bus.CD_VALID = 1'b1;
        @(negedge clk); check("hit_ar_en", ar_en, 1);
        n = 0;
        while (!bus.R_VALID && n < 20) begin @(negedge clk); n++; end
        check("hit_latency", n, 4);
        check("hit_sel_cd", rdata_sel_cd, 1);
        tick(); clr();
        @(negedge clk); check("hit_r_hold", bus.R_VALID, 1);
        tick(); bus.R_READY = 1'b1;
        tick(); bus.R_READY = 1'b0;
        @(negedge clk); check("hit_done_r", bus.R_VALID, 0); check("hit_idle_sel", rdata_sel_cd, 0);

        // ReadShared snoop miss served from memory
        read_miss_to_mem();
        tick();
        tick(); mem_ack_i = 1'b1;
        tick(); mem_ack_i = 1'b0; bus.R_READY = 1'b1;
        @(negedge clk); check("miss_r_valid", bus.R_VALID, 1); check("miss_sel_mem", rdata_sel_cd, 0);
        tick(); clr();

        // MakeUnique without data, AC stalled
        tick(); bus.AR_VALID = 1'b1; make_unique_i = 1'b1;
        tick(); bus.AR_VALID = 1'b0;
        @(negedge clk); check("mu_ac_valid", bus.AC_VALID, 1);
        tick(); bus.AC_READY = 1'b1;
        tick(); bus.AC_READY = 1'b0;
        @(negedge clk); check("mu_cr_ready", bus.CR_READY, 1);
        tick(); bus.CR_VALID = 1'b1;
        tick(); bus.CR_VALID = 1'b0;
        @(negedge clk); check("mu_r_valid", bus.R_VALID, 1); check("mu_no_mem", mem_req, 0);
        bus.R_READY = 1'b1;
        tick(); clr();

        // Simultaneous AW and AR: write first, AR accepted on the next IDLE
        tick(); bus.AW_VALID = 1'b1; bus.AR_VALID = 1'b1;
        @(negedge clk); check("arb_ar_ready", bus.AR_READY, 0); check("arb_ar_en", ar_en, 0);
        check("arb_aw_en", aw_en, 1);
        tick(); bus.AW_VALID = 1'b0; bus.W_VALID = 1'b1;
        tick(); bus.W_VALID = 1'b0; mem_ack_i = 1'b1;
        tick(); mem_ack_i = 1'b0; bus.B_READY = 1'b1;
        tick(); bus.B_READY = 1'b0; bus.AC_READY = 1'b1; bus.CR_VALID = 1'b1;
        @(negedge clk); check("arb_ar_after", ar_en, 1);
        tick(); bus.AR_VALID = 1'b0;
        tick();
        tick(); bus.AC_READY = 1'b0; bus.CR_VALID = 1'b0; mem_ack_i = 1'b1;
        tick(); mem_ack_i = 1'b0; bus.R_READY = 1'b1;
        tick(); clr();

        // Reset asserted mid-cycle while in R_MEM
        read_miss_to_mem();
        #2 rst = 1'b1;
        #1 check("rst_mid_outputs", int'(actual()), 0);
        tick();
        tick(); rst = 1'b0;
        @(negedge clk); check("rst_rel_aw_ready", bus.AW_READY, 1); check("rst_rel_mem_req", mem_req, 0);

`ifdef ACE_HOME_SNP_TIMEOUT_EN
        tick(); bus.AR_VALID = 1'b1; bus.AC_READY = 1'b1;
        tick(); bus.AR_VALID = 1'b0;
        tick(); bus.AC_READY = 1'b0;
        @(negedge clk);
        n = 0;
        while (!mem_req && n < 40) begin @(negedge clk); n++; end
        check("timeout_latency", n, 16);
        tick(); mem_ack_i = 1'b1;
        tick(); mem_ack_i = 1'b0; bus.R_READY = 1'b1;
        tick(); clr();
`endif

        repeat (2) tick();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/ace_home_ctrl.md
Name: ace_home_ctrl

Overview:
- Interconnect-side responder controller for the ACE link. Accepts WriteClean (AW/W) and ReadShared/MakeUnique (AR) from the requesting cache and snoops the peer cache (AC/CR/CD).
- Falls back to backing memory when the snoop supplies no data, then returns R or B.
- Control-only FSM: an external datapath holds addresses and data and is steered by the enable and select outputs below.
- Handles one outstanding transaction at a time.

Parameters:
- SNP_TIMEOUT, 16, cycles to wait in SNP_RESP before treating the snoop as a miss (used only with the optional feature).

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
AW_VALID  in  1  write address valid from requester
AW_READY  out  1  write address ready
W_VALID  in  1  write data valid
W_READY  out  1  write data ready
B_VALID  out  1  write response valid
B_READY  in  1  write response ready
AR_VALID  in  1  read address valid
AR_READY  out  1  read address ready
R_VALID  out  1  read data valid
R_READY  in  1  read data ready
AC_VALID  out  1  snoop address valid to peer
AC_READY  in  1  snoop address ready
CR_VALID  in  1  snoop response valid
CR_READY  out  1  snoop response ready
CD_VALID  in  1  snoop data valid
CD_READY  out  1  snoop data ready
make_unique_i  in  1  datapath decode of latched AR: 1 = MakeUnique (AC snoop MakeInvalid), 0 = ReadShared
data_xfer_i  in  1  CR.DataTransfer bit, valid while CR_VALID
mem_ack_i  in  1  memory access complete, one-cycle pulse
ar_en  out  1  latch AR address/type
aw_en  out  1  latch AW address
w_en  out  1  latch W data
cd_en  out  1  latch CD data
mem_req  out  1  memory request, held until mem_ack_i
mem_we  out  1  1 = memory write, 0 = memory read
rdata_sel_cd  out  1  R data source: 1 = CD register, 0 = memory register

Behaviour:
- Reset: state IDLE; every output 0. Assertion mid-transaction aborts it immediately, with no B/R issued. States are encoded as a 4-bit enum.
- Handshake rule: a transfer occurs on VALID&&READY at the clock edge. VALID outputs hold until accepted.
- IDLE:
  - AW_READY=1. AR_READY=!AW_VALID, so write wins a simultaneous request.
  - AW handshake: aw_en=1, go to W_DATA. AR handshake: ar_en=1, go to SNP_ADDR.
- W_DATA: W_READY=1. On W_VALID: w_en=1, go to W_MEM.
- W_MEM: mem_req=1, mem_we=1. On mem_ack_i go to B_RESP.
- B_RESP: B_VALID=1. On B_READY go to IDLE.
- SNP_ADDR: AC_VALID=1. On AC_READY go to SNP_RESP.
- SNP_RESP: CR_READY=1. On CR_VALID:
  - data_xfer_i=1: go to SNP_DATA.
  - else if make_unique_i: go to R_DATA.
  - else: go to R_MEM.
- SNP_DATA: CD_READY=1. On CD_VALID: cd_en=1, go to R_DATA. For MakeUnique the data is latched but discarded.
- R_MEM: mem_req=1, mem_we=0. On mem_ack_i go to R_DATA.
- R_DATA: R_VALID=1. rdata_sel_cd is registered: set to 1 on SNP_DATA exit, cleared in IDLE. On R_READY go to IDLE.
- Latency, zero-wait peers: read via snoop data is AR accept + 4 cycles to R_VALID. The write path has no snoop in this revision.
- Response codes (OKAY/SLVERR) are formed by the datapath from mem_err registered on mem_ack_i. The FSM does not branch on errors; the requester retries.
- Invalid state encoding goes to IDLE.

Optional Feature:
- Macro ACE_HOME_SNP_TIMEOUT_EN.
- Defined: a counter of width $clog2(SNP_TIMEOUT+1) clears on SNP_RESP entry and increments each cycle without CR_VALID. When it reaches SNP_TIMEOUT it goes to R_MEM (ReadShared) or R_DATA (MakeUnique). CR_VALID on the same cycle as expiry wins.
- Undefined: SNP_RESP waits indefinitely; no counter is synthesized.

Decomposition:
- Shared package ace_pkg holds:
  - state enum home_state_t
  - CR bit indices (DataTransfer=0, Error=1)
  - snoop codes SNP_READSHARED=4'b0001, SNP_MAKEINVALID=4'b1101
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10
- Optional sub-module ace_home_datapath (address/data registers, resp formation); the FSM stays in ace_home_ctrl.

Test Plan:
- Write: AW_VALID with ready AW → aw_en at that edge; W_VALID next cycle → w_en; mem_ack_i after 3 cycles → B_VALID; B_READY held low 2 cycles → B_VALID stays 1 until accepted, then IDLE.
- ReadShared snoop hit: AR, AC_READY=1, CR_VALID with data_xfer_i=1, CD_VALID → cd_en=1, R_VALID with rdata_sel_cd=1 exactly 4 cycles after AR accept.
- ReadShared snoop miss: data_xfer_i=0 → mem_req=1/mem_we=0 until mem_ack_i, then R_VALID with rdata_sel_cd=0; mem_req never asserted in SNP states.
- MakeUnique: make_unique_i=1, data_xfer_i=0 → no mem_req, R_VALID the cycle after CR accept.
- AW_VALID and AR_VALID asserted together in IDLE → AR_READY=0, write completes first, AR then accepted on its next IDLE cycle.
- Reset asserted in R_MEM with mem_req=1 → all outputs 0 in the same cycle; after release, IDLE with AW_READY=1. With ACE_HOME_SNP_TIMEOUT_EN and SNP_TIMEOUT=16, no CR_VALID → mem_req rises 16 cycles after SNP_RESP entry.
